wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter A_WIDTH, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter D_WIDTH, default 32, meaning register data width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 alloc_valid  input  1  issue stage wants to reserve destination register alloc_rd.
REQ-007 alloc_rd  input  A_WIDTH  destination register to reserve.
REQ-008 alloc_ready  output  1  reservation accepted this cycle.
REQ-009 req0_valid / req1_valid  input  1 each  ALU (0) / load unit (1) writeback request.
REQ-010 req0_rd / req1_rd  input  A_WIDTH each  writeback destination.
REQ-011 req0_data / req1_data  input  D_WIDTH each  writeback data.
REQ-012 req0_ready / req1_ready  output  1 each  request granted this cycle.
REQ-013 WE3  output  1  register-file write enable.
REQ-014 AD3  output  A_WIDTH  register-file write address.
REQ-015 WD3  output  D_WIDTH  register-file write data.
REQ-016 chk_rs1 / chk_rs2  input  A_WIDTH each  source registers to check.
REQ-017 rs1_busy / rs2_busy  output  1 each  source has an outstanding write.
REQ-018 pending  output  2**A_WIDTH  scoreboard, bit i = register i reserved.
REQ-019 stray_wr  output  1  sticky: a write arrived for an unreserved non-zero register.

Function
REQ-020 Arbitration SHALL be combinational: exactly one of reqN_ready high when any reqN_valid high; a transfer occurs when valid and ready are both high.
REQ-021 With one valid requester, it SHALL be granted in the same cycle.
REQ-022 With both valid, the requester not granted in the most recent two-way conflict SHALL win (round-robin); single-requester grants SHALL NOT change the priority pointer.
REQ-023 A granted transfer with rd != 0 SHALL register WE3=1, AD3=rd, WD3=data at that clock edge; write latency one cycle; throughput one write per cycle.
REQ-024 A granted transfer with rd == 0 SHALL be accepted but register WE3=0.
REQ-025 WE3 SHALL be a single-cycle pulse per transfer; with no transfer WE3 SHALL be 0 next cycle, AD3/WD3 holding last values.
REQ-026 alloc_ready SHALL be high iff pending[alloc_rd]==0 or alloc_rd==0 (combinational, current pending state).
REQ-027 An accepted allocation with alloc_rd != 0 SHALL set pending[alloc_rd] at the clock edge; alloc_rd==0 SHALL set nothing.
REQ-028 pending[AD3] SHALL clear at the edge where WE3==1 (data committed in register file that edge).
REQ-029 pending[0] SHALL always read 0.
REQ-030 rsN_busy SHALL equal pending[chk_rsN] combinationally; chk_rsN==0 SHALL give 0.
REQ-031 A granted transfer with rd != 0 and pending[rd]==0 SHALL still be written and SHALL set stray_wr, which holds until reset.
REQ-032 Simultaneous clear of pending[r] (WE3 to r) and allocation of r SHALL not occur: alloc_ready is low that cycle; allocation retried next cycle succeeds.
REQ-033 Simultaneous clear of pending[r] and set of pending[s], s != r, SHALL both take effect.

Reset
REQ-034 On a clock edge with rst high: pending=0, WE3=0, AD3=0, WD3=0, stray_wr=0, priority pointer favours req0.
REQ-035 During rst high, reqN_ready and alloc_ready SHALL be 0; no transfer or allocation occurs.
REQ-036 A write registered in the cycle before reset SHALL still present WE3=1 until the reset edge; reset mid-operation discards all outstanding reservations.

Verification
REQ-037 Alloc rd=5, then req0 rd=5 data=0xDEADBEEF -> next cycle WE3=1, AD3=5, WD3=0xDEADBEEF; pending[5] clears after that edge; rs1_busy(5) 1 then 0.
REQ-038 Both requesters valid for 4 cycles (rd 3 and 4, reserved) -> grants req0, req1, req0, req1; WE3 high each cycle.
REQ-039 req1 valid rd=0 data=0x1234 -> req1_ready=1, WE3 stays 0, pending unchanged.
REQ-040 Alloc rd=7 while pending[7]=1 -> alloc_ready=0; WE3 to 7 that cycle -> alloc retried next cycle accepted, pending[7]=1.
REQ-041 Write to unreserved rd=9 -> WE3=1, AD3=9, stray_wr=1 and stays 1 until rst.
REQ-042 Reserve rd 1,2,3, assert rst one cycle -> pending=0, WE3=0, stray_wr=0; next conflict grants req0.

Source files
------------

// File: rtl/wb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_arbiter: two-port round-robin writeback arbiter with register scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_valid,
  input  logic [A_WIDTH-1:0]      alloc_rd,
  output logic                    alloc_ready,
  input  logic                    req0_valid,
  input  logic [A_WIDTH-1:0]      req0_rd,
  input  logic [D_WIDTH-1:0]      req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [A_WIDTH-1:0]      req1_rd,
  input  logic [D_WIDTH-1:0]      req1_data,
  output logic                    req1_ready,
  output logic                    WE3,
  output logic [A_WIDTH-1:0]      AD3,
  output logic [D_WIDTH-1:0]      WD3,
  input  logic [A_WIDTH-1:0]      chk_rs1,
  input  logic [A_WIDTH-1:0]      chk_rs2,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic [(2**A_WIDTH)-1:0] pending,
  output logic                    stray_wr
);

  localparam int C_NREG = 2**A_WIDTH;

  logic [C_NREG-1:0]  pending_q, pending_d;
  logic               prio_q, prio_d;
  logic               we_q, we_d;
  logic [A_WIDTH-1:0] ad_q, ad_d;
  logic [D_WIDTH-1:0] wd_q, wd_d;
  logic               stray_q, stray_d;

  logic               w_gnt0, w_gnt1, w_xfer;
  logic [A_WIDTH-1:0] w_rd;
  logic [D_WIDTH-1:0] w_data;

  // prio_q == 1 means req1 wins the next two-way conflict
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        if (prio_q) w_gnt1 = 1'b1;
        else        w_gnt0 = 1'b1;
      end else if (req0_valid) begin
        w_gnt0 = 1'b1;
      end else if (req1_valid) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign w_xfer = w_gnt0 | w_gnt1;
  assign w_rd   = w_gnt1 ? req1_rd   : req0_rd;
  assign w_data = w_gnt1 ? req1_data : req0_data;

  // A pending register being written back this cycle is still marked busy,
  // so a same-register allocation is naturally refused until the next cycle.
  assign alloc_ready = !rst && ((alloc_rd == '0) || !pending_q[alloc_rd]);

  always_comb begin
    pending_d = pending_q;
    prio_d    = prio_q;
    we_d      = 1'b0;
    ad_d      = ad_q;
    wd_d      = wd_q;
    stray_d   = stray_q;

    if (req0_valid && req1_valid && !rst) prio_d = w_gnt0;

    if (w_xfer && (w_rd != '0)) begin
      we_d = 1'b1;
      ad_d = w_rd;
      wd_d = w_data;
      if (!pending_q[w_rd]) stray_d = 1'b1;
    end

    if (we_q) pending_d[ad_q] = 1'b0;
    if (alloc_valid && alloc_ready && (alloc_rd != '0)) pending_d[alloc_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      prio_q    <= 1'b0;
      we_q      <= 1'b0;
      ad_q      <= '0;
      wd_q      <= '0;
      stray_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      prio_q    <= prio_d;
      we_q      <= we_d;
      ad_q      <= ad_d;
      wd_q      <= wd_d;
      stray_q   <= stray_d;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign WE3        = we_q;
  assign AD3        = ad_q;
  assign WD3        = wd_q;
  assign pending    = pending_q;
  assign stray_wr   = stray_q;
  assign rs1_busy   = pending_q[chk_rs1];
  assign rs2_busy   = pending_q[chk_rs2];

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_arbiter: directed scoreboard bench for wb_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid;
  logic [AW-1:0] alloc_rd;
  logic          alloc_ready;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_rd, req1_rd;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          WE3;
  logic [AW-1:0] AD3;
  logic [DW-1:0] WD3;
  logic [AW-1:0] chk_rs1, chk_rs2;
  logic          rs1_busy, rs2_busy;
  logic [31:0]   pending;
  logic          stray_wr;

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  wb_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .WE3(WE3), .AD3(AD3), .WD3(WD3),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .pending(pending), .stray_wr(stray_wr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
  endtask

  // Register-file write monitor: every WE3 pulse must match the oldest expectation
  always @(negedge clk) begin
    if (WE3 === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_we3: got AD3=%0d WD3=0x%0h expected no write", AD3, WD3);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({AD3, WD3} !== e) begin
          errors++;
          $display("FAIL rf_write: got AD3=%0d WD3=0x%0h expected AD3=%0d WD3=0x%0h",
                   AD3, WD3, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; idle();
    alloc_rd = '0; req0_rd = '0; req1_rd = '0; req0_data = '0; req1_data = '0;
    chk_rs1 = '0; chk_rs2 = '0;

    // Reset: readies held low even with valid requests
    tick();
    alloc_valid = 1'b1; alloc_rd = 5'd6; req0_valid = 1'b1; req0_rd = 5'd6; req1_valid = 1'b1;
    #3;
    chk("rst_alloc_ready", alloc_ready, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    tick();
    rst = 1'b0; idle();
    #3;
    chk("rst_pending", pending, 0);
    chk("rst_we3", WE3, 0);
    chk("rst_ad3", AD3, 0);
    chk("rst_wd3", WD3, 0);
    chk("rst_stray", stray_wr, 0);

    // Reserve 5, write it back, watch busy clear
    tick();
    alloc_valid = 1'b1; alloc_rd = 5'd5; chk_rs1 = 5'd5; chk_rs2 = 5'd0;
    #3;
    chk("alloc5_ready", alloc_ready, 1);
    chk("rs1_busy_pre", rs1_busy, 0);
    tick();
    alloc_valid = 1'b0;
    req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEADBEEF;
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    #3;
    chk("w5_req0_ready", req0_ready, 1);
    chk("w5_req1_ready", req1_ready, 0);
    chk("rs1_busy_set", rs1_busy, 1);
    chk("rs2_busy_zero", rs2_busy, 0);
    chk("pending_5", pending, 32'h20);
    tick();
    idle();
    #3;
    chk("w5_we3", WE3, 1);
    chk("rs1_busy_during_we", rs1_busy, 1);
    tick();
    #3;
    chk("rs1_busy_clear", rs1_busy, 0);
    chk("we3_pulse_end", WE3, 0);
    chk("ad3_hold", AD3, 5);
    chk("wd3_hold", WD3, 32'hDEADBEEF);

    // Round-robin: reserve 3 and 4, then four cycles of conflict
    tick();
    alloc_valid = 1'b1; alloc_rd = 5'd3;
    tick();
    alloc_rd = 5'd4;
    tick();
    idle();
    req0_rd = 5'd3; req0_data = 32'h3333_0000;
    req1_rd = 5'd4; req1_data = 32'h4444_0000;
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      if (k % 2 == 0) exp_q.push_back({5'd3, 32'h3333_0000});
      else            exp_q.push_back({5'd4, 32'h4444_0000});
      #3;
      chk($sformatf("rr_req0_ready_%0d", k), req0_ready, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_req1_ready_%0d", k), req1_ready, (k % 2 == 0) ? 0 : 1);
      if (k > 0) chk($sformatf("rr_we3_%0d", k), WE3, 1);
      tick();
    end
    idle();
    tick();
    #3;
    // 3rd and 4th writes hit registers already released
    chk("rr_stray", stray_wr, 1);
    chk("rr_pending", pending, 0);

    // Write to r0: accepted, never written
    tick();
    req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h1234;
    #3;
    chk("r0_req1_ready", req1_ready, 1);
    tick();
    idle();
    #3;
    chk("r0_we3", WE3, 0);
    chk("r0_pending", pending, 0);

    // Clear stray with a one-cycle reset
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #3;
    chk("stray_cleared", stray_wr, 0);

    // Same-register clear/allocate collision on r7
    tick();
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    tick();
    alloc_valid = 1'b0;
    req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h77;
    exp_q.push_back({5'd7, 32'h77});
    tick();
    req0_valid = 1'b0;
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    #3;
    chk("c7_we3", WE3, 1);
    chk("c7_alloc_blocked", alloc_ready, 0);
    tick();
    #3;
    chk("c7_alloc_retry", alloc_ready, 1);
    tick();
    idle();
    #3;
    chk("c7_pending", pending, 32'h80);

    // Clear r7 while allocating r8 in the same cycle
    req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h7777;
    exp_q.push_back({5'd7, 32'h7777});
    tick();
    req0_valid = 1'b0;
    alloc_valid = 1'b1; alloc_rd = 5'd8;
    #3;
    chk("c8_alloc_ready", alloc_ready, 1);
    tick();
    idle();
    #3;
    chk("c8_pending", pending, 32'h100);
    chk("c8_stray", stray_wr, 0);

    // Stray write to unreserved r9
    req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h99;
    exp_q.push_back({5'd9, 32'h99});
    tick();
    idle();
    #3;
    chk("s9_stray_not_yet", stray_wr, 1);
    tick(); tick(); tick();
    #3;
    chk("s9_stray_sticky", stray_wr, 1);

    // Reserve 1,2,3, write r10 just before reset, then reset
    tick();
    alloc_valid = 1'b1; alloc_rd = 5'd1;
    tick(); alloc_rd = 5'd2;
    tick(); alloc_rd = 5'd3;
    tick();
    alloc_valid = 1'b0;
    req0_valid = 1'b1; req0_rd = 5'd10; req0_data = 32'hA0A0;
    exp_q.push_back({5'd10, 32'hA0A0});
    #3;
    chk("pre_rst_pending", pending, 32'h10E);
    tick();
    rst = 1'b1;
    req1_valid = 1'b1; req1_rd = 5'd2; alloc_valid = 1'b1; alloc_rd = 5'd11;
    #3;
    chk("rst_we3_held", WE3, 1);
    chk("rst2_req0_ready", req0_ready, 0);
    chk("rst2_alloc_ready", alloc_ready, 0);
    tick();
    rst = 1'b0; idle();
    #3;
    chk("post_rst_pending", pending, 0);
    chk("post_rst_we3", WE3, 0);
    chk("post_rst_stray", stray_wr, 0);
    chk("post_rst_ad3", AD3, 0);
    req0_valid = 1'b1; req0_rd = 5'd0; req1_valid = 1'b1; req1_rd = 5'd0;
    #1;
    chk("post_rst_prio_req0", req0_ready, 1);
    chk("post_rst_prio_req1", req1_ready, 0);
    tick();
    idle();
    tick(); tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
